// File: rtl/control_corrimiento.sv
// control_corrimiento: splits one large shift command into several passes of the
// shared barrel shift unit. Each pass's result is fed back as the next pass's input.
module control_corrimiento #(
    parameter int N  = 4,
    parameter int DW = (N - 1) / 2 + 1,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    cmd_op,
    input  logic [N-1:0]  cmd_data,
    input  logic [AW-1:0] cmd_amt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [AW-1:0] out_passes,
    output logic          busy,
    output logic [N-1:0]  sh_F,
    output logic [2:0]    sh_H,
    output logic [DW-1:0] sh_D,
    input  logic [N-1:0]  sh_S
);
    localparam int MAXSTEP = (1 << DW) - 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state, state_nx;
    logic [N-1:0]  acc;
    logic [AW-1:0] rem, rem_nx, passes;
    logic [2:0]    op;
    logic [DW-1:0] step;
    logic          special, accept;
    // xfer and clear never consume any of the amount
    always_comb begin
        special = (op == 3'b000) || (op == 3'b011);
        step    = special ? '0 : (rem > AW'(MAXSTEP)) ? DW'(MAXSTEP) : DW'(rem);
        rem_nx  = rem - AW'(step);
        accept  = (state == IDLE) && in_valid;
    end
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? RUN : IDLE;
            RUN:     state_nx = (rem_nx == '0) ? DONE : RUN;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            rem    <= '0;
            op     <= '0;
            passes <= '0;
        end else if (accept) begin
            acc    <= cmd_data;
            op     <= cmd_op;
            rem    <= ((cmd_op == 3'b000) || (cmd_op == 3'b011)) ? '0 : cmd_amt;
            passes <= '0;
        end else if (state == RUN) begin
            acc    <= sh_S;
            rem    <= rem_nx;
            passes <= passes + AW'(1);
        end
    end
    always_comb begin
        in_ready   = state == IDLE;
        out_valid  = state == DONE;
        busy       = state != IDLE;
        out_data   = acc;
        out_passes = passes;
        sh_F       = acc;
        sh_H       = (state == RUN) ? op : 3'b000;
        sh_D       = (state == RUN) ? step : '0;
    end
endmodule

// File: tb/tb_control_corrimiento.sv
// tb_control_corrimiento: scoreboard bench with a behavioural shift unit on the sh_* ports.
module tb_control_corrimiento;
    logic       clk = 0, rst;
    logic       in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0] cmd_op, sh_H;
    logic [3:0] cmd_data, cmd_amt, out_data, out_passes, sh_F, sh_S;
    logic [1:0] sh_D;
    int checks = 0, failures = 0, cyc = 0;

    typedef struct {logic [3:0] d; logic [3:0] p; int c;} exp_t;
    exp_t q[$];
    int mrem = 0;
    logic [2:0] mop = 0;
    logic pv = 0;

    control_corrimiento dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_amt(cmd_amt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_passes(out_passes), .busy(busy), .sh_F(sh_F), .sh_H(sh_H),
        .sh_D(sh_D), .sh_S(sh_S)
    );

    always #5 clk = ~clk;

    // Applies op a times, one position per step; used both as the unit and the reference
    function automatic logic [3:0] shift_n(input logic [2:0] o, input logic [3:0] d, input int a);
        logic [3:0] r = d;
        for (int i = 0; i < a; i++)
            case (o)
                3'd1, 3'd6: r = {r[2:0], 1'b0};
                3'd2:       r = {1'b0, r[3:1]};
                3'd4:       r = {r[2:0], r[3]};
                3'd5:       r = {r[0], r[3:1]};
                3'd7:       r = {r[3], r[3:1]};
                default:    r = r;
            endcase
        return (o == 3'd3) ? 4'b0 : r;
    endfunction

    always_comb sh_S = shift_n(sh_H, sh_F, int'(sh_D));

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int st;
        cyc++;
        if (rst) begin
            q.delete();
            mrem = 0;
            pv = 0;
        end else begin
            if (out_valid && !pv) begin
                if (q.size() == 0) chk("spurious_out", 1, 0);
                else chk("latency", cyc - q[0].c, int'(q[0].p) + 1);
            end
            pv = out_valid;
            if (busy && !out_valid) begin
                st = (mrem > 3) ? 3 : mrem;
                chk("sh_H_run", sh_H, mop);
                chk("sh_D_run", sh_D, st);
                mrem -= st;
            end else begin
                chk("sh_H_idle", sh_H, 0);
                chk("sh_D_idle", sh_D, 0);
            end
            if (out_valid) chk("in_ready_done", in_ready, 0);
            if (out_valid && out_ready && q.size() > 0) begin
                e = q.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_passes", out_passes, e.p);
            end
            if (in_valid && in_ready) begin
                e.d = shift_n(cmd_op, cmd_data, int'(cmd_amt));
                e.p = (cmd_op == 3'd0 || cmd_op == 3'd3 || cmd_amt == 0) ? 4'd1 : 4'((cmd_amt + 2) / 3);
                e.c = cyc;
                q.push_back(e);
                mop = cmd_op;
                mrem = (cmd_op == 3'd0 || cmd_op == 3'd3) ? 0 : int'(cmd_amt);
            end
        end
    end

    task automatic send(input logic [2:0] o, input logic [3:0] d, input logic [3:0] a);
        int n = 0;
        in_valid = 1; cmd_op = o; cmd_data = d; cmd_amt = a;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 0; cmd_op = 3'($urandom); cmd_data = 4'($urandom); cmd_amt = 4'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(out_valid && out_ready) && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("done_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0] hd, hp;
        rst = 1; in_valid = 0; out_ready = 1; cmd_op = 0; cmd_data = 0; cmd_amt = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_passes", out_passes, 0);
        @(posedge clk); #1 rst = 0;
        send(3'd1, 4'b0011, 4'd1);  wait_done();
        send(3'd5, 4'b1001, 4'd5);  wait_done();
        send(3'd7, 4'b1000, 4'd7);  wait_done();
        send(3'd1, 4'b1111, 4'd15); wait_done();
        send(3'd2, 4'b1010, 4'd0);  wait_done();
        out_ready = 0;
        send(3'd3, 4'b0110, 4'd9);
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        chk("bp_valid", out_valid, 1);
        hd = out_data; hp = out_passes;
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", out_data, hd);
            chk("bp_hold_passes", out_passes, hp);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1;
        in_valid = 1; cmd_op = 3'd4; cmd_data = 4'b0010; cmd_amt = 4'd1;
        @(negedge clk);
        chk("handoff_no_accept", in_ready, 0);
        @(negedge clk);
        chk("after_handoff_ready", in_ready, 1);
        chk("after_handoff_busy", busy, 0);
        @(posedge clk); #1 in_valid = 0;
        wait_done();
        send(3'd4, 4'b0001, 4'd12);
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sh_H", sh_H, 0);
        chk("mid_rst_sh_D", sh_D, 0);
        @(posedge clk); #1 rst = 0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            send(3'($urandom), 4'($urandom), 4'($urandom));
            wait_done();
        end
        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/control_corrimiento.md
Name: control_corrimiento

Overview:
- Sequencing controller for the shared N-bit barrel shift unit.
- The shift unit moves at most 2^DW-1 positions per pass. This block takes one command with a larger total amount and drives the unit over several passes, one per clock.
- Each pass's result is fed back as the next pass's input.
- Sits between a command source (valid/ready) and a result consumer (valid/ready). The shift unit itself is instantiated externally and connected through the sh_* ports.

Parameters:
- N, 4, data width; must match the shift unit.
- DW, (N-1)/2+1, width of the per-pass amount to the unit. MAXSTEP = 2^DW-1 (3 at defaults).
- AW, 4, width of the total shift amount per command.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  command valid.
- in_ready  output  1  command accepted when in_valid & in_ready at the clock edge.
- cmd_op  input  3  operation, unit H encoding: 000 xfer, 001 shl, 010 shr, 011 clear, 100 rol, 101 ror, 110 asl, 111 asr.
- cmd_data  input  N  operand.
- cmd_amt  input  AW  total shift amount.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer ready.
- out_data  output  N  result.
- out_passes  output  AW  number of unit passes used for this result.
- busy  output  1  high in RUN or DONE.
- sh_F  output  N  operand to the shift unit.
- sh_H  output  3  operation to the shift unit.
- sh_D  output  DW  per-pass amount to the shift unit.
- sh_S  input  N  shift unit result (combinational from sh_F/sh_H/sh_D).

Behaviour:
- Registers: state, acc (N), rem (AW), op (3), passes (AW).
- Reset (rst=1 at an edge): state=IDLE; acc, rem, op and passes = 0; out_valid=0; out_data=0; out_passes=0; busy=0; in_ready=1. Reset overrides every state, including mid-RUN and DONE. An in-flight command is dropped with no output.
- sh_F=acc at all times.
- sh_H=op and sh_D=step only in RUN; otherwise sh_H=000 and sh_D=0.
- step = min(rem, MAXSTEP). For op 000 or 011, step=0.
- IDLE:
  - in_ready=1.
  - On accept: acc<=cmd_data, op<=cmd_op, passes<=0, state<=RUN.
  - rem<=cmd_amt, except rem<=0 for op 000/011.
- RUN:
  - in_ready=0.
  - Each edge: acc<=sh_S, rem<=rem-step, passes<=passes+1.
  - If rem-step==0 then state<=DONE; otherwise stay in RUN.
  - Every command performs at least one pass. cmd_amt=0 gives one pass with D=0.
- Pass count P = max(1, ceil(cmd_amt/MAXSTEP)); P=1 for ops 000/011.
- DONE:
  - out_valid=1, out_data=acc, out_passes=passes, in_ready=0.
  - Outputs are held stable while out_ready=0.
  - On out_valid & out_ready at an edge: state<=IDLE.
  - A new command cannot be accepted in the same cycle as the handoff; the earliest accept is the following cycle.
- Latency: out_valid rises exactly P cycles after the accepting edge. Throughput is one command per P+2 cycles with out_ready held high.
- Outputs out_valid and in_ready are decoded from state only; there is no combinational path from out_ready or in_valid.
- Arithmetic:
  - rem subtraction is unsigned and never underflows because step ≤ rem.
  - Shift left/right by a total ≥ N saturates naturally to 0, or to the sign fill for asr.
  - Rotations wrap modulo N across passes.
- cmd_* values are ignored outside the accepting edge.

Test Plan:
- Single pass: shl, data 0011, amt 1 → out_data 0110; out_passes 1; out_valid high 1 cycle after accept; sh_D=1 during RUN.
- Multi-pass rotate: ror, data 1001, amt 5 → sh_D sequence 3 then 2; out_data 1100; out_passes 2.
- Arithmetic saturation: asr, data 1000, amt 7 → sh_D sequence 3, 3, 1; out_data 1111; out_passes 3.
- Maximum amount: shl, data 1111, amt 15 → 5 passes of 3; out_data 0000. Also: shr, data 1010, amt 0 → 1 pass with D=0; out_data 1010.
- Special ops and back-pressure:
  - clear, data 0110, amt 9 → 1 pass with sh_D=0; out_data 0000.
  - Hold out_ready=0 for 3 cycles → out_data, out_valid and out_passes stable; in_ready=0.
  - Raise out_ready → IDLE next cycle; next command accepted no earlier than the cycle after the handoff.
- Reset mid-operation: rol, data 0001, amt 12; assert rst during the 2nd RUN cycle → next cycle state IDLE, in_ready=1, out_valid=0, busy=0, sh_H=000, sh_D=0, and no output is ever produced for the dropped command.
